// File: rtl/pcx2mb_req_queue.sv
// Circular request queue from the SPARC PCX request port to the MicroBlaze FSL read side.
// Admission reserves space for both words of an atomic pair; grants return in PX.
module pcx2mb_req_queue #(
  parameter int DATA_W   = 124,
  parameter int DEPTH    = 8,
  parameter int REQ5     = 0,
  parameter int AFULL_TH = 6,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                                     rclk,
  input  logic                                     reset_l,
  input  logic                                     any_req_pa,
  input  logic [4:0]                               req_dest_pa,
  input  logic                                     req_atom_pa,
  input  logic [DATA_W-1:0]                        spc_pcx_data_pa,
  output logic [4:0]                               pcx_spc_grant_px,
  output logic                                     req_drop_pa,
  output logic [DATA_W+((REQ5 != 0) ? 5 : 2):0]    out_data,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [CNT_W-1:0]                         occupancy,
  output logic                                     almost_full,
  output logic                                     proto_err
);

  localparam int HDR_W = (REQ5 != 0) ? 5 : 2;
  localparam int ENT_W = DATA_W + HDR_W + 1;
  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic is_onehot(input logic [4:0] v);
    return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
  endfunction

  // Compressed header folds dest[3:0] into one "any of the low four" bit.
  function automatic logic [ENT_W-1:0] make_entry(input logic [4:0] dest, input logic atom,
                                                  input logic [DATA_W-1:0] data);
    logic [DATA_W+5:0] full;
    if (REQ5 != 0) begin
      full = {dest, atom, data};
    end else begin
      full = {3'b000, dest[4], |dest[3:0], atom, data};
    end
    return full[ENT_W-1:0];
  endfunction

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] occupancy_q, occupancy_d;
  logic             atom_pending_q, atom_pending_d;
  logic [4:0]       atom_dest_q, atom_dest_d;
  logic [4:0]       grant_q, grant_d;
  logic             proto_err_q, proto_err_d;

  logic             dest_ok_s, accept_s, pop_s;
  logic [CNT_W-1:0] free_s, need_s;
  logic [PTR_W-1:0] new_idx_s;
  logic [1:0]       wr_cnt_s;

  assign out_valid   = (occupancy_q != {CNT_W{1'b0}});
  assign occupancy   = occupancy_q;
  assign almost_full = (occupancy_q >= CNT_W'(AFULL_TH));
  assign proto_err   = proto_err_q;
  assign pcx_spc_grant_px = grant_q;
  assign out_data    = out_valid ? mem_q[rptr_q] : {ENT_W{1'b0}};

  // Admission decision, pointer/occupancy update and entry writes.
  always_comb begin
    dest_ok_s = is_onehot(req_dest_pa);
    free_s    = CNT_W'(DEPTH) - occupancy_q;
    need_s    = CNT_W'(atom_pending_q) + (req_atom_pa ? CNT_W'(2) : CNT_W'(1));
    accept_s  = any_req_pa && dest_ok_s && (free_s >= need_s);
    req_drop_pa = reset_l && any_req_pa && !accept_s;
    pop_s     = out_valid && out_ready;
    wr_cnt_s  = {1'b0, atom_pending_q} + {1'b0, accept_s};
    new_idx_s = wptr_q + PTR_W'(atom_pending_q);

    mem_d = mem_q;
    // The pending second word always lands first so the pair stays adjacent.
    if (atom_pending_q) begin
      mem_d[wptr_q] = make_entry(atom_dest_q, (REQ5 != 0) ? 1'b1 : 1'b0, spc_pcx_data_pa);
    end else begin
      mem_d[wptr_q] = mem_q[wptr_q];
    end
    if (accept_s) begin
      mem_d[new_idx_s] = make_entry(req_dest_pa, req_atom_pa, spc_pcx_data_pa);
    end else begin
      mem_d[new_idx_s] = mem_d[new_idx_s];
    end

    wptr_d         = wptr_q + PTR_W'(wr_cnt_s);
    rptr_d         = pop_s ? (rptr_q + PTR_W'(1)) : rptr_q;
    occupancy_d    = occupancy_q + CNT_W'(wr_cnt_s) - CNT_W'(pop_s);
    atom_pending_d = accept_s && req_atom_pa;
    atom_dest_d    = (accept_s && req_atom_pa) ? req_dest_pa : atom_dest_q;
    grant_d        = accept_s ? req_dest_pa : 5'd0;
    proto_err_d    = proto_err_q || (any_req_pa && !dest_ok_s) || (out_ready && !out_valid);
  end

  // Control state with asynchronous clear.
  always_ff @(posedge rclk or negedge reset_l) begin
    if (!reset_l) begin
      wptr_q         <= {PTR_W{1'b0}};
      rptr_q         <= {PTR_W{1'b0}};
      occupancy_q    <= {CNT_W{1'b0}};
      atom_pending_q <= 1'b0;
      atom_dest_q    <= 5'd0;
      grant_q        <= 5'd0;
      proto_err_q    <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      occupancy_q    <= occupancy_d;
      atom_pending_q <= atom_pending_d;
      atom_dest_q    <= atom_dest_d;
      grant_q        <= grant_d;
      proto_err_q    <= proto_err_d;
    end
  end

  // Entry storage; contents are qualified by occupancy so no reset is needed.
  always_ff @(posedge rclk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_pcx2mb_req_queue.sv
// Randomised scoreboard bench for pcx2mb_req_queue; runs compressed and 5-bit header
// variants in lockstep against one queue-based reference model.
module tb_pcx2mb_req_queue;
  localparam int DATA_W = 124;
  localparam int DEPTH = 8;
  localparam int AFULL_TH = 6;
  localparam int CNT_W = 4;

  logic rclk = 1'b0;
  logic reset_l = 1'b0;
  logic any_req_pa = 1'b0;
  logic [4:0] req_dest_pa = 5'd0;
  logic req_atom_pa = 1'b0;
  logic [DATA_W-1:0] spc_pcx_data_pa = '0;
  logic out_ready = 1'b0;

  logic [4:0] grant0, grant1;
  logic drop0, drop1, valid0, valid1, afull0, afull1, perr0, perr1;
  logic [DATA_W+2:0] out_data0;
  logic [DATA_W+5:0] out_data1;
  logic [CNT_W-1:0] occ0, occ1;

  always #5 rclk = ~rclk;

  pcx2mb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REQ5(0), .AFULL_TH(AFULL_TH)) dut0 (
    .rclk(rclk), .reset_l(reset_l), .any_req_pa(any_req_pa), .req_dest_pa(req_dest_pa),
    .req_atom_pa(req_atom_pa), .spc_pcx_data_pa(spc_pcx_data_pa), .pcx_spc_grant_px(grant0),
    .req_drop_pa(drop0), .out_data(out_data0), .out_valid(valid0), .out_ready(out_ready),
    .occupancy(occ0), .almost_full(afull0), .proto_err(perr0));

  pcx2mb_req_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REQ5(1), .AFULL_TH(AFULL_TH)) dut1 (
    .rclk(rclk), .reset_l(reset_l), .any_req_pa(any_req_pa), .req_dest_pa(req_dest_pa),
    .req_atom_pa(req_atom_pa), .spc_pcx_data_pa(spc_pcx_data_pa), .pcx_spc_grant_px(grant1),
    .req_drop_pa(drop1), .out_data(out_data1), .out_valid(valid1), .out_ready(out_ready),
    .occupancy(occ1), .almost_full(afull1), .proto_err(perr1));

  typedef struct {
    logic [4:0]        dest;
    logic              atom;
    logic              second;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t sb[$];
  int compared = 0;
  int mismatched = 0;

  int         m_occ = 0;
  logic       m_pend = 1'b0;
  logic [4:0] m_pdest = 5'd0;
  logic [4:0] m_grant = 5'd0;
  logic       m_proto = 1'b0;
  logic       last_drop = 1'b0;

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W+2:0] exp0(input ent_t e);
    return {e.dest[4], |e.dest[3:0], (e.second ? 1'b0 : e.atom), e.data};
  endfunction

  function automatic logic [DATA_W+5:0] exp1(input ent_t e);
    return {e.dest, e.atom, e.data};
  endfunction

  // Monitor: pops the scoreboard whenever the head is consumed.
  always @(negedge rclk) begin
    ent_t e;
    if (reset_l) begin
      chk("occ_bound", 136'(occ0 <= CNT_W'(DEPTH)), 136'(1));
      if (valid0 && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_has_entry", 136'(sb.size()), 136'(1));
        end else begin
          e = sb.pop_front();
          chk("out_data0", 136'(out_data0), 136'(exp0(e)));
          chk("out_data1", 136'(out_data1), 136'(exp1(e)));
        end
      end
    end
  end

  // One PA cycle: drive, check against the model, advance the model.
  task automatic step(input logic any, input logic [4:0] dest, input logic atom, input logic rdy);
    logic [DATA_W-1:0] d;
    logic oh, acc, pop;
    int need;
    d = DATA_W'({$urandom(), $urandom(), $urandom(), $urandom()});
    any_req_pa = any; req_dest_pa = dest; req_atom_pa = atom;
    spc_pcx_data_pa = d; out_ready = rdy;
    @(negedge rclk);
    oh   = $onehot(dest);
    need = int'(m_pend) + (atom ? 2 : 1);
    acc  = any && oh && ((DEPTH - m_occ) >= need);
    pop  = (m_occ > 0) && rdy;
    chk("drop0", 136'(drop0), 136'(any && !acc));
    chk("drop1", 136'(drop1), 136'(any && !acc));
    chk("occ0", 136'(occ0), 136'(m_occ));
    chk("occ1", 136'(occ1), 136'(m_occ));
    chk("afull", 136'({afull0, afull1}), 136'({2{m_occ >= AFULL_TH}}));
    chk("valid", 136'({valid0, valid1}), 136'({2{m_occ != 0}}));
    chk("grant", 136'({grant0, grant1}), 136'({m_grant, m_grant}));
    chk("proto", 136'({perr0, perr1}), 136'({m_proto, m_proto}));
    last_drop = drop0;
    if (m_pend) sb.push_back('{dest: m_pdest, atom: 1'b1, second: 1'b1, data: d});
    if (acc) sb.push_back('{dest: dest, atom: atom, second: 1'b0, data: d});
    m_proto = m_proto || (any && !oh) || (rdy && m_occ == 0);
    m_occ   = m_occ + int'(m_pend) + int'(acc) - int'(pop);
    m_grant = acc ? dest : 5'd0;
    if (acc && atom) m_pdest = dest;
    m_pend  = acc && atom;
    @(posedge rclk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 4 && m_occ > 0; i++) step(1'b0, 5'd0, 1'b0, 1'b1);
    chk("drained", 136'(m_occ), 136'(0));
  endtask

  initial begin
    logic [4:0] rd;
    repeat (2) @(posedge rclk);
    #1 reset_l = 1'b1;

    // 1: three plain requests, no pops
    for (int i = 0; i < 3; i++) step(1'b1, 5'b00010, 1'b0, 1'b0);
    chk("t1_occ", 136'(occ0), 136'(3));
    chk("t1_hdr", 136'(out_data0[DATA_W+2:DATA_W]), 136'(3'b010));
    // 2: fill to DEPTH then overflow
    for (int i = 0; i < 5; i++) step(1'b1, 5'b01000, 1'b0, 1'b0);
    step(1'b1, 5'b10000, 1'b0, 1'b0);
    chk("t2_drop", 136'(last_drop), 136'(1));
    chk("t2_full", 136'({afull0, occ0}), 136'({1'b1, 4'd8}));
    drain();
    // 3: atomic needs two slots; a same-cycle pop gives no credit
    for (int i = 0; i < 7; i++) step(1'b1, 5'b00001, 1'b0, 1'b0);
    step(1'b1, 5'b00100, 1'b1, 1'b0);
    chk("t3_drop", 136'(last_drop), 136'(1));
    step(1'b1, 5'b00100, 1'b1, 1'b1);
    chk("t3_drop_pop", 136'(last_drop), 136'(1));
    step(1'b1, 5'b00100, 1'b1, 1'b0);
    chk("t3_accept", 136'(last_drop), 136'(0));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("t3_occ", 136'(occ0), 136'(8));
    drain();
    // 4: new request during the second-word cycle
    step(1'b1, 5'b10000, 1'b1, 1'b0);
    step(1'b1, 5'b00010, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("t4_occ", 136'(occ0), 136'(3));
    drain();
    // 5: streaming push/pop with wrap
    step(1'b1, 5'b00001, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) step(1'b1, 5'(1 << (i % 5)), 1'b0, 1'b1);
    chk("t5_occ", 136'(occ0), 136'(1));
    drain();
    // 6: non-one-hot destination, then reset during a pending atomic
    step(1'b1, 5'b00110, 1'b0, 1'b0);
    chk("t6_drop", 136'(last_drop), 136'(1));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("t6_proto", 136'(perr0), 136'(1));
    step(1'b1, 5'b00100, 1'b1, 1'b0);
    reset_l = 1'b0; any_req_pa = 1'b1; req_dest_pa = 5'b00110; out_ready = 1'b1;
    #1;
    chk("rst_grant", 136'({grant0, grant1}), 136'(0));
    chk("rst_drop", 136'({drop0, drop1}), 136'(0));
    chk("rst_valid", 136'({valid0, valid1}), 136'(0));
    chk("rst_data", 136'({out_data0, out_data1}), 136'(0));
    chk("rst_occ", 136'({occ0, occ1, afull0, afull1}), 136'(0));
    chk("rst_proto", 136'({perr0, perr1}), 136'(0));
    sb.delete();
    m_occ = 0; m_pend = 1'b0; m_grant = 5'd0; m_proto = 1'b0;
    @(posedge rclk); #1;
    any_req_pa = 1'b0; req_dest_pa = 5'd0; out_ready = 1'b0;
    #2 reset_l = 1'b1;
    step(1'b1, 5'b01000, 1'b0, 1'b0);
    step(1'b0, 5'd0, 1'b0, 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      rd = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : 5'(1 << $urandom_range(0, 4));
      step(($urandom_range(0, 9) < 7), rd, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
    end
    drain();
    chk("sb_empty_end", 136'(sb.size()), 136'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pcx2mb_req_queue.md
Name: pcx2mb_req_queue

Overview:
- Parametrised circular request queue between the SPARC PCX request port and the MicroBlaze FSL read side.
- Replaces the fixed shift-register entry chain with a DEPTH-entry RAM-style FIFO.
- Adds explicit admission control with slot reservation for atomic pairs, PX-stage grant generation, occupancy and almost-full reporting, and a sticky protocol-error flag.
- Sits between the SPARC core pipeline (PA/PX stages) and the FSL master interface.

Parameters:
- DATA_W, 124: PCX packet width.
- DEPTH, 8: number of entries; power of two, at least 4.
- REQ5, 0: entry header mode. 1 = 5-bit destination header; 0 = 2-bit compressed header.
- AFULL_TH, 6: occupancy at or above which `almost_full` asserts (1..DEPTH).
- CNT_W, clog2(DEPTH+1): width of the occupancy count.

Ports:
- `rclk`, in, 1: clock.
- `reset_l`, in, 1: asynchronous active-low reset.
- `any_req_pa`, in, 1: new request in PA stage.
- `req_dest_pa`, in, 5: one-hot destination of the PA request.
- `req_atom_pa`, in, 1: PA request is the first packet of an atomic pair.
- `spc_pcx_data_pa`, in, DATA_W: packet data. Carries the first word in PA and the second atomic word in the following cycle.
- `pcx_spc_grant_px`, out, 5: per-destination grant, PX stage.
- `req_drop_pa`, out, 1: PA request rejected this cycle; the core retries.
- `out_data`, out, DATA_W+(REQ5?5:2)+1: head entry.
- `out_valid`, out, 1: queue non-empty.
- `out_ready`, in, 1: FSL side consumes head.
- `occupancy`, out, CNT_W: current entry count.
- `almost_full`, out, 1: occupancy >= AFULL_TH.
- `proto_err`, out, 1: sticky protocol error.

Behaviour:
- Reset (async, `reset_l`=0): the following are all cleared immediately:
  - write/read pointers, `occupancy`, `atom_pending`
  - `pcx_spc_grant_px`, `req_drop_pa`, `proto_err`
  - `out_valid`=0, `out_data`=0
- Reset mid-atomic discards the pending second word.
- Entry format:
  - REQ5=1: {dest[4:0], atom, data}.
  - REQ5=0: {dest[4], |dest[3:0], atom, data}.
  - The second atomic word carries atom=1 when REQ5=1 and atom=0 when REQ5=0. Its dest is copied from the first word.
- Free slots: free = DEPTH - occupancy, using the registered value at the start of the cycle. A same-cycle pop does NOT add admission credit.
- Admission:
  - need = atom_pending + (req_atom_pa ? 2 : 1).
  - A PA request is accepted iff `any_req_pa`, `req_dest_pa` is one-hot, and free >= need.
  - Accepted: write entry at wptr, and register `pcx_spc_grant_px` = `req_dest_pa` for exactly the next cycle (1-cycle latency, PA->PX).
  - If atomic: set `atom_pending` for the next cycle.
  - Rejected for space: `req_drop_pa`=1 combinationally in the same cycle; no grant, no write.
- Atomic second word:
  - In a cycle with `atom_pending`=1, the second word is written unconditionally; its slot was reserved at admission.
  - `atom_pending` clears after the write.
  - No grant is issued for the second word.
- Simultaneous writes: a second atomic word and a new PA request in the same cycle are both written. The second word goes to wptr and the new request to wptr+1, so pair order is preserved. wptr advances by 2.
- Pop: when `out_valid` && `out_ready`, rptr advances by 1.
  - `occupancy` next = occupancy + writes - pop. Writes are 0..2.
  - Push and pop in the same cycle are both honoured.
- `out_data` is the combinational read of entry[rptr].
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full is defined by `occupancy`==DEPTH, never by pointer equality.
- `almost_full` is combinational from the registered `occupancy`.
- `proto_err` sets and stays set until reset when either:
  - `any_req_pa` arrives with a non-one-hot `req_dest_pa` (the request is ignored and dropped), or
  - `out_ready` is high while `out_valid`=0 and a pop is attempted: sampled while empty, no pointer change.
- Occupancy never exceeds DEPTH; with the admission rule this holds by construction. Assertions in the bench check it.

Test Plan:
1. Reset, then 3 non-atomic requests to dest 5'b00010 with `out_ready`=0 -> three PX grants of 5'b00010; `occupancy`=3; `out_data` header (REQ5=0) = 2'b01, atom=1'b0.
2. Fill to DEPTH=8 with `out_ready`=0, then one more request -> `req_drop_pa`=1, no grant, `occupancy` stays 8, `almost_full`=1 from count 6.
3. Fill to occupancy 7, then atomic request -> dropped (need 2). Pop 1, retry -> accepted; next cycle second word written; `occupancy`=8. REQ5=1: both entries carry atom=1.
4. Atomic request, then a new non-atomic PA request during the second-word cycle -> order in FIFO is atom-1st, atom-2nd, new; wptr +2 that cycle.
5. Continuous push/pop at `out_ready`=1 for 20 packets at DEPTH=8 -> wrap-around with FIFO order preserved and `occupancy` constant at 1.
6. `req_dest_pa`=5'b00110 -> request ignored, `proto_err`=1. Assert `reset_l` low mid-atomic -> all outputs 0 immediately, `proto_err` cleared.
